// File: rtl/alu_operand_control.sv
// Multicycle CPU control FSM: sequences ALU operand selects and datapath enables
// from a registered state, stretching FETCH/MREAD by a MEM_LAT wait counter.
module alu_operand_control #(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  output logic       alusrca,
  output logic [2:0] alusrcb,
  output logic [1:0] aluop,
  output logic [1:0] pcsource,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_wr,
  output logic       ir_write,
  output logic       mdr_write,
  output logic       a_write,
  output logic       b_write,
  output logic       aluout_write,
  output logic       reg_write,
  output logic       regdst,
  output logic       memtoreg,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_RST    = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MADDR  = 4'd3,
    S_MREAD  = 4'd4,
    S_MWB    = 4'd5,
    S_MWRITE = 4'd6,
    S_REXEC  = 4'd7,
    S_RWB    = 4'd8,
    S_BRANCH = 4'd9,
    S_IEXEC  = 4'd10,
    S_IWB    = 4'd11,
    S_AMEXEC = 4'd12,
    S_JUMP   = 4'd13,
    S_HALT   = 4'd14
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_ADDM  = 6'h01;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [2:0] LAT      = 3'(MEM_LAT);

  state_e     state_q;
  logic [2:0] cnt_q;
  logic [5:0] op_q;
  logic       illegal_q;
  logic       last_s;

  assign last_s  = (cnt_q == LAT);
  assign state   = state_q;
  assign illegal = illegal_q;

  // State, wait counter, latched opcode and sticky illegal flag.
  // The counter is cleared on every transition, so it starts at 0 in each read state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_RST;
      cnt_q     <= 3'd0;
      op_q      <= 6'd0;
      illegal_q <= 1'b0;
    end else begin
      cnt_q <= 3'd0;
      case (state_q)
        S_RST:    state_q <= S_FETCH;
        S_FETCH: begin
          if (last_s) begin
            state_q <= S_DECODE;
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        S_DECODE: begin
          op_q <= opcode;
          case (opcode)
            OP_RTYPE:             state_q <= S_REXEC;
            OP_ADDI:              state_q <= S_IEXEC;
            OP_LW, OP_SW, OP_ADDM: state_q <= S_MADDR;
            OP_BEQ:               state_q <= S_BRANCH;
            OP_J:                 state_q <= S_JUMP;
            default: begin
              state_q   <= S_HALT;
              illegal_q <= 1'b1;
            end
          endcase
        end
        S_MADDR:  state_q <= (op_q == OP_SW) ? S_MWRITE : S_MREAD;
        S_MREAD: begin
          if (last_s) begin
            state_q <= (op_q == OP_ADDM) ? S_AMEXEC : S_MWB;
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        S_MWB:    state_q <= S_FETCH;
        S_MWRITE: state_q <= S_FETCH;
        S_REXEC:  state_q <= S_RWB;
        S_RWB:    state_q <= S_FETCH;
        S_BRANCH: state_q <= S_FETCH;
        S_IEXEC:  state_q <= S_IWB;
        S_AMEXEC: state_q <= S_IWB;
        S_IWB:    state_q <= S_FETCH;
        S_JUMP:   state_q <= S_FETCH;
        S_HALT:   state_q <= S_HALT;
        default: begin
          state_q   <= S_HALT;
          illegal_q <= 1'b1;
        end
      endcase
    end
  end

  // Moore output decode; only pc_en in BRANCH looks at a live input (zero).
  always_comb begin
    alusrca      = 1'b0;
    alusrcb      = 3'd0;
    aluop        = 2'b00;
    pcsource     = 2'd0;
    pc_en        = 1'b0;
    iord         = 1'b0;
    mem_wr       = 1'b0;
    ir_write     = 1'b0;
    mdr_write    = 1'b0;
    a_write      = 1'b0;
    b_write      = 1'b0;
    aluout_write = 1'b0;
    reg_write    = 1'b0;
    regdst       = 1'b0;
    memtoreg     = 1'b0;
    case (state_q)
      S_FETCH: begin
        alusrcb  = 3'd1;
        ir_write = last_s;
        pc_en    = last_s;
      end
      S_DECODE: begin
        alusrcb      = 3'd3;
        aluout_write = 1'b1;
        a_write      = 1'b1;
        b_write      = 1'b1;
      end
      S_MADDR: begin
        alusrca      = 1'b1;
        alusrcb      = 3'd2;
        aluout_write = 1'b1;
      end
      S_MREAD: begin
        iord      = 1'b1;
        mdr_write = last_s;
      end
      S_MWB: begin
        memtoreg  = 1'b1;
        reg_write = 1'b1;
      end
      S_MWRITE: begin
        iord   = 1'b1;
        mem_wr = 1'b1;
      end
      S_REXEC: begin
        alusrca      = 1'b1;
        aluop        = 2'b10;
        aluout_write = 1'b1;
      end
      S_RWB: begin
        regdst    = 1'b1;
        reg_write = 1'b1;
      end
      S_BRANCH: begin
        alusrca  = 1'b1;
        aluop    = 2'b01;
        pcsource = 2'd1;
        pc_en    = zero;
      end
      S_IEXEC: begin
        alusrca      = 1'b1;
        alusrcb      = 3'd2;
        aluout_write = 1'b1;
      end
      S_AMEXEC: begin
        alusrca      = 1'b1;
        alusrcb      = 3'd4;
        aluout_write = 1'b1;
      end
      S_IWB:    reg_write = 1'b1;
      S_JUMP: begin
        pcsource = 2'd2;
        pc_en    = 1'b1;
      end
      default: alusrcb = 3'd0;
    endcase
  end

endmodule

// File: tb/tb_alu_operand_control.sv
// Directed bench for alu_operand_control: instance A uses MEM_LAT=1, instance B MEM_LAT=2.
module tb_alu_operand_control;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] opcode;
  logic       zero;

  logic       a_alusrca, a_pc_en, a_iord, a_mem_wr, a_ir_write, a_mdr_write, a_a_write, a_b_write;
  logic       a_aluout_write, a_reg_write, a_regdst, a_memtoreg, a_illegal;
  logic [2:0] a_alusrcb;
  logic [1:0] a_aluop, a_pcsource;
  logic [3:0] a_state;

  logic       b_alusrca, b_pc_en, b_iord, b_mem_wr, b_ir_write, b_mdr_write, b_a_write, b_b_write;
  logic       b_aluout_write, b_reg_write, b_regdst, b_memtoreg, b_illegal;
  logic [2:0] b_alusrcb;
  logic [1:0] b_aluop, b_pcsource;
  logic [3:0] b_state;

  int total = 0;
  int bad   = 0;

  int st1 [7]  = '{0, 1, 1, 2, 7, 8, 1};
  int sb1 [7]  = '{0, 1, 1, 3, 0, 0, 1};
  int st2 [11] = '{0, 1, 1, 1, 2, 3, 4, 4, 4, 5, 1};
  int st3 [10] = '{0, 1, 1, 2, 3, 4, 4, 12, 11, 1};
  int sb3 [10] = '{0, 1, 1, 3, 2, 0, 0, 4, 0, 1};
  logic [5:0] legal_ops [7] = '{6'h00, 6'h08, 6'h23, 6'h2B, 6'h01, 6'h04, 6'h02};

  alu_operand_control #(.MEM_LAT(1)) u_a (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .zero(zero),
    .alusrca(a_alusrca), .alusrcb(a_alusrcb), .aluop(a_aluop), .pcsource(a_pcsource),
    .pc_en(a_pc_en), .iord(a_iord), .mem_wr(a_mem_wr), .ir_write(a_ir_write),
    .mdr_write(a_mdr_write), .a_write(a_a_write), .b_write(a_b_write),
    .aluout_write(a_aluout_write), .reg_write(a_reg_write), .regdst(a_regdst),
    .memtoreg(a_memtoreg), .illegal(a_illegal), .state(a_state)
  );

  alu_operand_control #(.MEM_LAT(2)) u_b (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .zero(zero),
    .alusrca(b_alusrca), .alusrcb(b_alusrcb), .aluop(b_aluop), .pcsource(b_pcsource),
    .pc_en(b_pc_en), .iord(b_iord), .mem_wr(b_mem_wr), .ir_write(b_ir_write),
    .mdr_write(b_mdr_write), .a_write(b_a_write), .b_write(b_b_write),
    .aluout_write(b_aluout_write), .reg_write(b_reg_write), .regdst(b_regdst),
    .memtoreg(b_memtoreg), .illegal(b_illegal), .state(b_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [5:0] op);
    reset_n = 1'b0;
    opcode  = op;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    opcode  = 6'h00;
    zero    = 1'b0;
    #3;
    chk("rst_state", 8'(a_state), 8'd0);
    chk("rst_illegal", 8'(a_illegal), 8'd0);
    chk("rst_srcb", 8'(a_alusrcb), 8'd0);

    // R-type, MEM_LAT=1
    do_reset(6'h00);
    for (int i = 0; i < 7; i++) begin
      chk("t1_state", 8'(a_state), 8'(st1[i]));
      chk("t1_srcb", 8'(a_alusrcb), 8'(sb1[i]));
      chk("t1_irw", 8'(a_ir_write), 8'(i == 2));
      chk("t1_pcen", 8'(a_pc_en), 8'(i == 2));
      if (i == 4) chk("t1_aluop", 8'(a_aluop), 8'd2);
      if (i == 5) chk("t1_regdst", 8'(a_regdst), 8'd1);
      if (i < 6) cyc();
    end

    // lw on instance B, MEM_LAT=2
    do_reset(6'h23);
    for (int i = 0; i < 11; i++) begin
      chk("t2_state", 8'(b_state), 8'(st2[i]));
      chk("t2_mdr", 8'(b_mdr_write), 8'(i == 8));
      chk("t2_iord", 8'(b_iord), 8'(i >= 6 && i <= 8));
      chk("t2_memtoreg", 8'(b_memtoreg), 8'(i == 9));
      chk("t2_regwr", 8'(b_reg_write), 8'(i == 9));
      chk("t2_irw", 8'(b_ir_write), 8'(i == 3));
      if (i < 10) cyc();
    end

    // addm, live opcode changed after DECODE to prove the latched copy is used
    do_reset(6'h01);
    for (int i = 0; i < 10; i++) begin
      chk("t3_state", 8'(a_state), 8'(st3[i]));
      chk("t3_srcb", 8'(a_alusrcb), 8'(sb3[i]));
      chk("t3_srca", 8'(a_alusrca), 8'(i == 4 || i == 7));
      chk("t3_regwr", 8'(a_reg_write), 8'(i == 8));
      if (i == 7) chk("t3_aluoutw", 8'(a_aluout_write), 8'd1);
      if (i == 8) chk("t3_regdst", 8'(a_regdst), 8'd0);
      if (i == 8) chk("t3_memtoreg", 8'(a_memtoreg), 8'd0);
      if (i == 4) opcode = 6'h2B;
      if (i < 9) cyc();
    end

    // beq taken then not taken
    zero = 1'b1;
    do_reset(6'h04);
    repeat (4) cyc();
    chk("t4_state_t", 8'(a_state), 8'd9);
    chk("t4_pcen_t", 8'(a_pc_en), 8'd1);
    chk("t4_pcsrc_t", 8'(a_pcsource), 8'd1);
    chk("t4_aluop_t", 8'(a_aluop), 8'd1);
    zero = 1'b0;
    #1;
    chk("t4_pcen_live", 8'(a_pc_en), 8'd0);
    repeat (4) cyc();
    chk("t4_state_n", 8'(a_state), 8'd9);
    chk("t4_pcen_n", 8'(a_pc_en), 8'd0);
    chk("t4_pcsrc_n", 8'(a_pcsource), 8'd1);
    chk("t4_aluop_n", 8'(a_aluop), 8'd1);

    // jump, then addi
    do_reset(6'h02);
    repeat (4) cyc();
    chk("t5_state_j", 8'(a_state), 8'd13);
    chk("t5_pcen_j", 8'(a_pc_en), 8'd1);
    chk("t5_pcsrc_j", 8'(a_pcsource), 8'd2);
    cyc();
    chk("t5_state_f", 8'(a_state), 8'd1);
    opcode = 6'h08;
    repeat (2) cyc();
    chk("t5_state_d", 8'(a_state), 8'd2);
    cyc();
    chk("t5_state_ie", 8'(a_state), 8'd10);
    chk("t5_srcb_ie", 8'(a_alusrcb), 8'd2);
    chk("t5_srca_ie", 8'(a_alusrca), 8'd1);
    cyc();
    chk("t5_state_iwb", 8'(a_state), 8'd11);
    chk("t5_regwr_iwb", 8'(a_reg_write), 8'd1);
    chk("t5_memtoreg_iwb", 8'(a_memtoreg), 8'd0);
    cyc();
    chk("t5_state_end", 8'(a_state), 8'd1);

    // sw: single-cycle mem_wr, then reset in the middle of MWRITE
    do_reset(6'h2B);
    repeat (5) cyc();
    chk("t6_state_mw", 8'(a_state), 8'd6);
    chk("t6_memwr", 8'(a_mem_wr), 8'd1);
    chk("t6_iord", 8'(a_iord), 8'd1);
    cyc();
    chk("t6_state_f", 8'(a_state), 8'd1);
    chk("t6_memwr_off", 8'(a_mem_wr), 8'd0);
    repeat (4) cyc();
    chk("t6_state_mw2", 8'(a_state), 8'd6);
    chk("t6_memwr2", 8'(a_mem_wr), 8'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_async_memwr", 8'(a_mem_wr), 8'd0);
    chk("t6_async_state", 8'(a_state), 8'd0);
    chk("t6_async_iord", 8'(a_iord), 8'd0);

    // illegal opcode: sticky HALT until reset
    do_reset(6'h3F);
    repeat (4) cyc();
    chk("t7_state_h", 8'(a_state), 8'd14);
    chk("t7_illegal", 8'(a_illegal), 8'd1);
    opcode = 6'h00;
    for (int i = 0; i < 20; i++) begin
      cyc();
      chk("t7_hold_state", 8'(a_state), 8'd14);
      chk("t7_hold_illegal", 8'(a_illegal), 8'd1);
      chk("t7_hold_en", 8'({a_pc_en, a_mem_wr, a_ir_write, a_mdr_write,
                           a_a_write, a_b_write, a_aluout_write, a_reg_write}), 8'd0);
    end
    #2;
    reset_n = 1'b0;
    #1;
    chk("t7_clr_illegal", 8'(a_illegal), 8'd0);
    chk("t7_clr_state", 8'(a_state), 8'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    cyc();
    chk("t7_resume", 8'(a_state), 8'd1);

    // random legal opcodes: alusrcb stays within 0..4, never illegal
    do_reset(6'h00);
    for (int i = 0; i < 300; i++) begin
      opcode = legal_ops[$urandom_range(0, 6)];
      zero   = 1'($urandom_range(0, 1));
      cyc();
      chk("t8_srcb_range", 8'(a_alusrcb <= 3'd4), 8'd1);
      chk("t8_srcb_range_b", 8'(b_alusrcb <= 3'd4), 8'd1);
      chk("t8_no_illegal", 8'(a_illegal), 8'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
